// File: rtl/calibration_pattern_gen.sv
// Transmit side of LED-ID calibration: paints each LED's own address on the strand,
// one ID bit per pass (MSB first), and hands each pass to the calibration FSM.
module calibration_pattern_gen #(
    parameter int          NUM_LEDS          = 50,
    parameter int          LED_ADDRESS_WIDTH = 10,
    parameter logic [23:0] COLOR_0           = 24'hFF0000,
    parameter logic [23:0] COLOR_1           = 24'h0000FF,
    parameter logic [23:0] COLOR_OFF         = 24'h000000,
    localparam int         BIT_W             = $clog2(LED_ADDRESS_WIDTH)
) (
    input  logic                         clk_pixel,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         next_led_request,
    input  logic [LED_ADDRESS_WIDTH-1:0] next_led,
    input  logic                         frame_done,
    input  logic                         cal_busy,
    output logic [23:0]                  color_out,
    output logic                         color_valid,
    output logic                         increment_id,
    output logic                         should_overwrite,
    output logic [BIT_W-1:0]             bit_index,
    output logic                         busy,
    output logic                         done
);

    localparam logic [BIT_W-1:0] TOP_BIT = BIT_W'(LED_ADDRESS_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, SYNC, SETTLE, TRIGGER, CAPTURE, NEXT, DONE
    } state_t;

    state_t           state, state_n;
    logic             start_d;
    logic             seen_busy, seen_n;
    logic [BIT_W-1:0] bit_n;
    logic             busy_n, done_n, inc_n, ovw_n;
    logic [23:0]      color_n;
    logic             start_edge;

    assign start_edge = start && !start_d;

    always_comb begin
        state_n = state;
        bit_n   = bit_index;
        busy_n  = busy;
        done_n  = done;
        seen_n  = seen_busy;
        inc_n   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_edge) begin
                    state_n = SYNC;
                    bit_n   = TOP_BIT;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                end
            end
            // A request for address 0 marks the first frame drawn with the current bit.
            SYNC: begin
                if (next_led_request && next_led == '0) state_n = SETTLE;
            end
            // Any frame_done seen here belongs to the fresh frame, never the previous one.
            SETTLE: begin
                if (frame_done) begin
                    state_n = TRIGGER;
                    inc_n   = 1'b1;
                end
            end
            TRIGGER: begin
                state_n = CAPTURE;
                seen_n  = 1'b0;
            end
            CAPTURE: begin
                if (cal_busy) seen_n = 1'b1;
                if (seen_busy && !cal_busy) state_n = NEXT;
            end
            NEXT: begin
                if (bit_index == '0) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    bit_n   = bit_index - BIT_W'(1);
                    state_n = SYNC;
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            bit_n   = TOP_BIT;
            inc_n   = 1'b0;
        end
        // Registered so it is already valid in the cycle increment_id pulses.
        ovw_n = busy_n && (bit_n == TOP_BIT);
    end

    always_comb begin
        color_n = COLOR_OFF;
        if (state != IDLE && state != DONE && int'(next_led) < NUM_LEDS)
            color_n = next_led[bit_index] ? COLOR_1 : COLOR_0;
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            state            <= IDLE;
            start_d          <= 1'b0;
            seen_busy        <= 1'b0;
            bit_index        <= TOP_BIT;
            busy             <= 1'b0;
            done             <= 1'b0;
            increment_id     <= 1'b0;
            should_overwrite <= 1'b0;
            color_out        <= COLOR_OFF;
            color_valid      <= 1'b0;
        end else begin
            state            <= state_n;
            start_d          <= start;
            seen_busy        <= seen_n;
            bit_index        <= bit_n;
            busy             <= busy_n;
            done             <= done_n;
            increment_id     <= inc_n;
            should_overwrite <= ovw_n;
            color_valid      <= next_led_request;
            if (next_led_request) color_out <= color_n;
        end
    end

endmodule

// File: tb/tb_calibration_pattern_gen.sv
// Bench for calibration_pattern_gen: directed steps plus randomized strand/camera
// activity, checked against an address/bit colour model and a pulse scoreboard.
module tb_calibration_pattern_gen;

    localparam int          NUM_LEDS = 50;
    localparam int          AW       = 10;
    localparam logic [23:0] C0       = 24'hFF0000;
    localparam logic [23:0] C1       = 24'h0000FF;
    localparam logic [23:0] COFF     = 24'h000000;

    logic          clk, rst, start, abort;
    logic          next_led_request, frame_done, cal_busy;
    logic [AW-1:0] next_led;
    logic [23:0]   color_out;
    logic          color_valid, increment_id, should_overwrite, busy, done;
    logic [3:0]    bit_index;

    logic          strand_en, cal_en;
    logic          d_req, d_fd, d_busy, s_req, s_fd, c_busy;
    logic [AW-1:0] d_addr, s_addr;

    assign next_led_request = strand_en ? s_req : d_req;
    assign next_led         = strand_en ? s_addr : d_addr;
    assign frame_done       = strand_en ? s_fd : d_fd;
    assign cal_busy         = cal_en ? c_busy : d_busy;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int pulse_cnt = 0;
    logic [4:0] exp_q[$];   // {should_overwrite, bit_index} per expected increment_id
    logic       prev_inc = 1'b0;

    calibration_pattern_gen dut (
        .clk_pixel        (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .next_led_request (next_led_request),
        .next_led         (next_led),
        .frame_done       (frame_done),
        .cal_busy         (cal_busy),
        .color_out        (color_out),
        .color_valid      (color_valid),
        .increment_id     (increment_id),
        .should_overwrite (should_overwrite),
        .bit_index        (bit_index),
        .busy             (busy),
        .done             (done)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Colour the strand should show for an address while a given ID bit is displayed.
    function automatic logic [23:0] model_color(input bit active, input int bit_pos, input int addr);
        if (!active || addr >= NUM_LEDS) return COFF;
        return (((addr >> bit_pos) & 1) == 1) ? C1 : C0;
    endfunction

    // Strand driver: frames of requests 0..NUM_LEDS-1 with random gaps, then frame_done.
    initial begin
        s_req = 1'b0; s_addr = '0; s_fd = 1'b0;
        forever begin
            tick();
            if (strand_en) begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    s_req = 1'b1; s_addr = AW'(i);
                    tick();
                    s_req = 1'b0;
                    if ($urandom_range(0, 3) == 0) tick();
                end
                repeat ($urandom_range(0, 2)) tick();
                s_fd = 1'b1;
                tick();
                s_fd = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
        end
    end

    // Calibration FSM stand-in: busy for 20 cycles a short random time after each pulse.
    initial begin
        c_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (cal_en && increment_id) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                c_busy = 1'b1;
                repeat (20) @(negedge clk);
                c_busy = 1'b0;
            end
        end
    end

    // Pulse scoreboard
    always @(negedge clk) begin
        if (increment_id) begin
            logic [4:0] e;
            pulse_cnt++;
            check("inc_width", 32'(prev_inc), 32'd0);
            check("pulse_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pulse_bit", 32'(bit_index), 32'(e[3:0]));
                check("pulse_ovw", 32'(should_overwrite), 32'(e[4]));
            end
        end
        prev_inc = increment_id;
    end

    task automatic do_request(input int addr, input bit active, input int b);
        d_req = 1'b1; d_addr = AW'(addr);
        tick();
        d_req = 1'b0;
        check("color_valid", 32'(color_valid), 32'd1);
        check("color_out", 32'(color_out), 32'(model_color(active, b, addr)));
    endtask

    // Walk one ID bit from SYNC to the following SYNC/DONE with directed stimulus.
    task automatic advance_bit(input int b, input bit early_fd);
        int base;
        base = pulse_cnt;
        exp_q.push_back({(b == AW - 1) ? 1'b1 : 1'b0, 4'(b)});
        if (early_fd) begin
            d_fd = 1'b1; tick(); d_fd = 1'b0;
            repeat (3) tick();
            check("early_fd_no_pulse", 32'(pulse_cnt - base), 32'd0);
            d_fd = 1'b1;
        end
        do_request(0, 1'b1, b);
        d_fd = 1'b0;
        if (early_fd) begin
            repeat (5) tick();
            check("coincident_fd_no_pulse", 32'(pulse_cnt - base), 32'd0);
        end
        d_fd = 1'b1;
        tick();
        d_fd = 1'b0;
        check("color_valid_drop", 32'(color_valid), 32'd0);
        check("inc_rise", 32'(increment_id), 32'd1);
        tick();
        check("inc_fall", 32'(increment_id), 32'd0);
        d_busy = 1'b1;
        repeat (3) tick();
        d_busy = 1'b0;
        tick();
        tick();
        check("pulse_count", 32'(pulse_cnt - base), 32'd1);
        check("bit_step", 32'(bit_index), 32'((b == 0) ? 0 : b - 1));
    endtask

    initial begin
        int n, base, a;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        d_req = 1'b0; d_addr = '0; d_fd = 1'b0; d_busy = 1'b0;
        strand_en = 1'b0; cal_en = 1'b0;

        // T1: reset values and idle colour reply
        repeat (3) tick();
        check("rst_color_out", 32'(color_out), 32'd0);
        check("rst_color_valid", 32'(color_valid), 32'd0);
        check("rst_inc", 32'(increment_id), 32'd0);
        check("rst_ovw", 32'(should_overwrite), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bit", 32'(bit_index), 32'd9);
        rst = 1'b0;
        tick();
        do_request(5, 1'b0, 9);
        tick();
        check("idle_valid_drop", 32'(color_valid), 32'd0);

        // T2 + T4: directed walk through all bits with colour checks
        start = 1'b1; tick(); start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_bit", 32'(bit_index), 32'd9);
        check("start_ovw", 32'(should_overwrite), 32'd1);
        for (int b = AW - 1; b >= 0; b--) begin
            do_request($urandom_range(1, 1023), 1'b1, b);
            do_request($urandom_range(1, 63), 1'b1, b);
            if (b == 9 || b == 2) do_request(5, 1'b1, b);
            if (b == 5) do_request(50, 1'b1, b);
            if (b == 0) do_request(49, 1'b1, b);
            if (b == 8) check("ovw_after_msb", 32'(should_overwrite), 32'd0);
            advance_bit(b, b == 7);
        end
        check("t2_done", 32'(done), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        check("t2_ovw", 32'(should_overwrite), 32'd0);
        do_request(5, 1'b0, 0);

        // T3: full run with random strand and camera timing
        strand_en = 1'b1; cal_en = 1'b1;
        for (int b = AW - 1; b >= 0; b--) exp_q.push_back({(b == AW - 1) ? 1'b1 : 1'b0, 4'(b)});
        base = pulse_cnt;
        start = 1'b1; tick(); start = 1'b0;
        check("t3_done_cleared", 32'(done), 32'd0);
        n = 0;
        while (!done && n < 20000) begin tick(); n++; end
        check("t3_timeout", 32'(n < 20000), 32'd1);
        check("t3_pulses", 32'(pulse_cnt - base), 32'd10);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_bit", 32'(bit_index), 32'd0);
        strand_en = 1'b0; cal_en = 1'b0;
        tick();

        // T5: abort during CAPTURE at bit 4, with a colour reply in flight
        start = 1'b1; tick(); start = 1'b0;
        for (int b = AW - 1; b >= 5; b--) advance_bit(b, 1'b0);
        exp_q.push_back({1'b0, 4'd4});
        do_request(0, 1'b1, 4);
        d_fd = 1'b1; tick(); d_fd = 1'b0;
        tick();
        d_busy = 1'b1; tick(); tick();
        a = $urandom_range(0, 49);
        abort = 1'b1; d_req = 1'b1; d_addr = AW'(a);
        tick();
        d_req = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bit", 32'(bit_index), 32'd9);
        check("abort_ovw", 32'(should_overwrite), 32'd0);
        check("abort_reply_valid", 32'(color_valid), 32'd1);
        check("abort_reply_color", 32'(color_out), 32'(model_color(1'b1, 4, a)));
        abort = 1'b0; d_busy = 1'b0;
        tick();
        check("abort_stays_idle", 32'(busy), 32'd0);
        do_request(5, 1'b0, 9);
        start = 1'b1; tick(); start = 1'b0;
        check("restart_bit", 32'(bit_index), 32'd9);
        check("restart_ovw", 32'(should_overwrite), 32'd1);
        advance_bit(9, 1'b0);
        abort = 1'b1; tick(); abort = 1'b0;

        // T6: start held high during a run gives one run only
        strand_en = 1'b1; cal_en = 1'b1;
        for (int b = AW - 1; b >= 0; b--) exp_q.push_back({(b == AW - 1) ? 1'b1 : 1'b0, 4'(b)});
        base = pulse_cnt;
        start = 1'b1;
        n = 0;
        while (!done && n < 20000) begin
            tick(); n++;
            if (n == 100) start = 1'b0;
        end
        start = 1'b0;
        check("t6_timeout", 32'(n < 20000), 32'd1);
        check("t6_pulses", 32'(pulse_cnt - base), 32'd10);
        repeat (200) tick();
        check("t6_single_run", 32'(pulse_cnt - base), 32'd10);
        check("t6_done_held", 32'(done), 32'd1);
        strand_en = 1'b0; cal_en = 1'b0;
        tick();

        // T6: reset while in SETTLE suppresses the pending pulse
        start = 1'b1; tick(); start = 1'b0;
        do_request(0, 1'b1, 9);
        base = pulse_cnt;
        rst = 1'b1; tick();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_bit", 32'(bit_index), 32'd9);
        check("mid_rst_color", 32'(color_out), 32'd0);
        check("mid_rst_ovw", 32'(should_overwrite), 32'd0);
        rst = 1'b0;
        d_fd = 1'b1; tick(); d_fd = 1'b0;
        repeat (10) tick();
        check("mid_rst_no_pulse", 32'(pulse_cnt - base), 32'd0);
        check("mid_rst_idle", 32'(busy), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
